dfi_init_seq: RTL and testbench
===============================

Name: dfi_init_seq

Overview:
- DDR3 power-up initialisation sequencer on the controller (master) side of the DFI boundary.
- Sits directly upstream of the PHY and drives the DFI control and status signals until the DRAM is usable:
  - PHY init handshake
  - RESET#/CKE timing
  - MRS programming (MR2, MR3, MR1, MR0)
  - ZQCL
- Afterwards it raises init_done, and the scheduler's command path takes over the DFI control bus.

Parameters:
- C_ROW_WIDTH, 16, width of dfi_address
- C_BANK_WIDTH, 3, width of dfi_bank
- T_RESET_CYC, 80000, cycles dfi_reset_n held low (≥200 us)
- T_CKE_CYC, 200000, cycles from reset_n release to CKE high (≥500 us)
- T_XPR_CYC, 120, cycles of NOP after CKE high before first MRS
- T_MRD_CYC, 4, MRS-to-MRS spacing in cycles
- T_MOD_CYC, 12, MR0-to-ZQCL spacing in cycles
- T_ZQINIT_CYC, 512, ZQCL-to-init_done spacing in cycles
- MR0_VAL, MR1_VAL, MR2_VAL, MR3_VAL, 16'h0000 each, mode register payloads driven on dfi_address

Ports:
- clk  in  1  controller clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; begins sequence when sampled high in IDLE
- init_done  out  1  sequence complete; DFI control bus released to scheduler
- busy  out  1  high in every state except IDLE and DONE
- dfi_init_start  out  1  request to PHY to initialise
- dfi_init_complete  in  1  PHY initialisation finished
- dfi_address  out  C_ROW_WIDTH  MRS payload / A10 for ZQCL
- dfi_bank  out  C_BANK_WIDTH  MR select for MRS
- dfi_ras_n, dfi_cas_n, dfi_we_n  out  1 each  command encoding
- dfi_cs_n  out  1  chip select
- dfi_cke  out  1  clock enable
- dfi_odt  out  1  on-die termination (held 0)
- dfi_reset_n  out  1  DRAM RESET#

Behaviour:
- Reset values (async, rst_n low):
  - dfi_reset_n=0, dfi_cke=0, dfi_cs_n=1
  - dfi_ras_n=dfi_cas_n=dfi_we_n=1
  - dfi_address=0, dfi_bank=0, dfi_odt=0
  - dfi_init_start=0, init_done=0, busy=0
  - state=IDLE, counter=0
- All outputs are registered. A single down-counter of width clog2(max T)+1 is loaded with T-1 on entry to each timed state. A parameter value of 0 is treated as 1.
- Command encodings (cs_n,ras_n,cas_n,we_n):
  - DESELECT = 1,1,1,1
  - NOP = 0,1,1,1
  - MRS = 0,0,0,0 with dfi_bank = MR index and dfi_address = MRx_VAL
  - ZQCL = 0,1,1,0 with dfi_address[10]=1 and all other address bits 0
- States and transitions:
  - IDLE: all outputs at reset values. start=1 → PHY_INIT.
  - PHY_INIT: dfi_init_start=1. When dfi_init_complete=1 is sampled, go to RST and drop dfi_init_start in the same transition.
  - RST: dfi_reset_n=0, dfi_cke=0, DESELECT for exactly T_RESET_CYC cycles, then → CKE_WAIT.
  - CKE_WAIT: dfi_reset_n=1, dfi_cke=0 for exactly T_CKE_CYC cycles, then → XPR.
  - XPR: dfi_cke=1, NOP for T_XPR_CYC cycles, then → MRS.
  - MRS: issues MR2, MR3, MR1, MR0 in that order, one command cycle each.
    - Consecutive MRS commands are exactly T_MRD_CYC cycles apart, with NOP in between.
    - After MR0, NOP for T_MOD_CYC-1 cycles, then → ZQ.
  - ZQ: one ZQCL cycle, then NOP for T_ZQINIT_CYC-1 cycles, then → DONE.
  - DONE: init_done=1; dfi_cke=1, dfi_reset_n=1, NOP held. Terminal until rst_n.
- dfi_cke, once high, never falls before reset. dfi_odt stays 0 throughout.
- start is ignored outside IDLE. A start pulse of one cycle is sufficient.
- If dfi_init_complete is already high when PHY_INIT is entered: dfi_init_start is high for exactly 1 cycle.
- If dfi_init_complete falls after PHY_INIT has exited: ignored (no restart).
- rst_n asserted mid-sequence: immediate return to the reset values (dfi_reset_n=0, dfi_cke=0). The sequence restarts from IDLE on the next start.

Test Plan:
All scenarios use T_RESET=10, T_CKE=20, T_XPR=5, T_MRD=4, T_MOD=12, T_ZQINIT=16, MR0..3 = 16'h0520, 16'h0044, 16'h0008, 16'h0000.
1. Reset then idle for 50 cycles, start=0 → all outputs at reset values; busy=0.
2. start pulse; PHY raises dfi_init_complete 7 cycles after dfi_init_start → dfi_init_start high exactly 7 cycles; dfi_reset_n low for exactly 10 cycles, then high; dfi_cke rises exactly 20 cycles later.
3. Full sequence check:
   - MRS on bank 2, 3, 1, 0 with addresses 0008, 0000, 0044, 0520, spaced 4 cycles apart.
   - ZQCL (addr 16'h0400) exactly 12 cycles after MR0.
   - init_done rises exactly 16 cycles after ZQCL.
   - Total count from start to init_done matches the sum of all intervals.
4. dfi_init_complete held high before start → dfi_init_start pulses for 1 cycle; remaining timing is identical to scenario 3.
5. rst_n asserted during the MRS gap after MR3 → same cycle: dfi_cke=0, dfi_reset_n=0, cs_n=1, busy=0. A new start reruns the full sequence from PHY_INIT.
6. start toggled repeatedly while busy, and dfi_init_complete dropped in DONE → no timing change; init_done stays 1; outputs hold NOP.

Source files
------------

// File: rtl/dfi_init_seq.sv
// DDR3 power-up initialisation sequencer, controller side of the DFI boundary.
// Walks PHY init handshake, RESET#/CKE timing, MRS (MR2, MR3, MR1, MR0) and
// ZQCL, then raises init_done and releases the DFI control bus.
module dfi_init_seq #(
    parameter int unsigned C_ROW_WIDTH  = 16,
    parameter int unsigned C_BANK_WIDTH = 3,
    parameter int unsigned T_RESET_CYC  = 80000,
    parameter int unsigned T_CKE_CYC    = 200000,
    parameter int unsigned T_XPR_CYC    = 120,
    parameter int unsigned T_MRD_CYC    = 4,
    parameter int unsigned T_MOD_CYC    = 12,
    parameter int unsigned T_ZQINIT_CYC = 512,
    parameter logic [C_ROW_WIDTH-1:0] MR0_VAL = 16'h0000,
    parameter logic [C_ROW_WIDTH-1:0] MR1_VAL = 16'h0000,
    parameter logic [C_ROW_WIDTH-1:0] MR2_VAL = 16'h0000,
    parameter logic [C_ROW_WIDTH-1:0] MR3_VAL = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    init_done,
    output logic                    busy,
    output logic                    dfi_init_start,
    input  logic                    dfi_init_complete,
    output logic [C_ROW_WIDTH-1:0]  dfi_address,
    output logic [C_BANK_WIDTH-1:0] dfi_bank,
    output logic                    dfi_ras_n,
    output logic                    dfi_cas_n,
    output logic                    dfi_we_n,
    output logic                    dfi_cs_n,
    output logic                    dfi_cke,
    output logic                    dfi_odt,
    output logic                    dfi_reset_n
);

    // A timing parameter of 0 behaves as 1 cycle.
    localparam int unsigned E_RESET  = (T_RESET_CYC  == 0) ? 1 : T_RESET_CYC;
    localparam int unsigned E_CKE    = (T_CKE_CYC    == 0) ? 1 : T_CKE_CYC;
    localparam int unsigned E_XPR    = (T_XPR_CYC    == 0) ? 1 : T_XPR_CYC;
    localparam int unsigned E_MRD    = (T_MRD_CYC    == 0) ? 1 : T_MRD_CYC;
    localparam int unsigned E_MOD    = (T_MOD_CYC    == 0) ? 1 : T_MOD_CYC;
    localparam int unsigned E_ZQINIT = (T_ZQINIT_CYC == 0) ? 1 : T_ZQINIT_CYC;

    localparam int unsigned MAX_A = (E_RESET > E_CKE) ? E_RESET : E_CKE;
    localparam int unsigned MAX_B = (E_XPR > E_MRD) ? E_XPR : E_MRD;
    localparam int unsigned MAX_C = (E_MOD > E_ZQINIT) ? E_MOD : E_ZQINIT;
    localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_T = (MAX_D > MAX_C) ? MAX_D : MAX_C;
    localparam int unsigned CW    = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] LD_RESET  = CW'(E_RESET - 1);
    localparam logic [CW-1:0] LD_CKE    = CW'(E_CKE - 1);
    localparam logic [CW-1:0] LD_XPR    = CW'(E_XPR - 1);
    localparam logic [CW-1:0] LD_MRD    = CW'(E_MRD - 1);
    localparam logic [CW-1:0] LD_MOD    = CW'(E_MOD - 1);
    localparam logic [CW-1:0] LD_ZQINIT = CW'(E_ZQINIT - 1);

    // ZQCL carries A10=1, every other address bit 0.
    localparam logic [C_ROW_WIDTH-1:0] ZQ_ADDR = {{(C_ROW_WIDTH-11){1'b0}}, 1'b1, 10'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PHY_INIT,
        S_RST,
        S_CKE_WAIT,
        S_XPR,
        S_MRS,
        S_ZQ,
        S_DONE
    } state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [1:0]              idx, idx_nx;
    logic                    issue_mrs, issue_zq;
    logic                    init_done_nx, busy_nx, init_start_nx;
    logic                    reset_n_nx, cke_nx, cs_n_nx, ras_n_nx, cas_n_nx, we_n_nx;
    logic [C_ROW_WIDTH-1:0]  addr_nx;
    logic [C_BANK_WIDTH-1:0] bank_nx;

    // State, counter and all DFI outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            init_done      <= 1'b0;
            busy           <= 1'b0;
            dfi_init_start <= 1'b0;
            dfi_reset_n    <= 1'b0;
            dfi_cke        <= 1'b0;
            dfi_cs_n       <= 1'b1;
            dfi_ras_n      <= 1'b1;
            dfi_cas_n      <= 1'b1;
            dfi_we_n       <= 1'b1;
            dfi_address    <= '0;
            dfi_bank       <= '0;
            dfi_odt        <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            idx            <= idx_nx;
            init_done      <= init_done_nx;
            busy           <= busy_nx;
            dfi_init_start <= init_start_nx;
            dfi_reset_n    <= reset_n_nx;
            dfi_cke        <= cke_nx;
            dfi_cs_n       <= cs_n_nx;
            dfi_ras_n      <= ras_n_nx;
            dfi_cas_n      <= cas_n_nx;
            dfi_we_n       <= we_n_nx;
            dfi_address    <= addr_nx;
            dfi_bank       <= bank_nx;
            dfi_odt        <= 1'b0;
        end
    end

    // Next state plus the output values for the cycle about to begin; outputs
    // are decoded from the next state so the registered bus lines up with it.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = (cnt == '0) ? '0 : cnt - 1'b1;
        issue_mrs = 1'b0;
        issue_zq  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nx = S_PHY_INIT;
            end
            S_PHY_INIT: begin
                if (dfi_init_complete) begin
                    state_nx = S_RST;
                    cnt_nx   = LD_RESET;
                end
            end
            S_RST: begin
                if (cnt == '0) begin
                    state_nx = S_CKE_WAIT;
                    cnt_nx   = LD_CKE;
                end
            end
            S_CKE_WAIT: begin
                if (cnt == '0) begin
                    state_nx = S_XPR;
                    cnt_nx   = LD_XPR;
                end
            end
            S_XPR: begin
                if (cnt == '0) begin
                    state_nx  = S_MRS;
                    idx_nx    = 2'd0;
                    cnt_nx    = LD_MRD;
                    issue_mrs = 1'b1;
                end
            end
            S_MRS: begin
                if (cnt == '0) begin
                    if (idx == 2'd3) begin
                        state_nx = S_ZQ;
                        cnt_nx   = LD_ZQINIT;
                        issue_zq = 1'b1;
                    end else begin
                        idx_nx    = idx + 2'd1;
                        issue_mrs = 1'b1;
                        // MR0 is the last MRS; its gap to ZQCL is tMOD.
                        cnt_nx    = (idx == 2'd2) ? LD_MOD : LD_MRD;
                    end
                end
            end
            S_ZQ: begin
                if (cnt == '0) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase

        init_done_nx  = 1'b0;
        busy_nx       = 1'b0;
        init_start_nx = 1'b0;
        reset_n_nx    = 1'b0;
        cke_nx        = 1'b0;
        cs_n_nx       = 1'b1;
        ras_n_nx      = 1'b1;
        cas_n_nx      = 1'b1;
        we_n_nx       = 1'b1;
        addr_nx       = '0;
        bank_nx       = '0;

        case (state_nx)
            S_PHY_INIT: begin
                busy_nx       = 1'b1;
                init_start_nx = 1'b1;
            end
            S_RST: begin
                busy_nx = 1'b1;
            end
            S_CKE_WAIT: begin
                busy_nx    = 1'b1;
                reset_n_nx = 1'b1;
            end
            S_XPR, S_MRS, S_ZQ: begin
                busy_nx    = 1'b1;
                reset_n_nx = 1'b1;
                cke_nx     = 1'b1;
                cs_n_nx    = 1'b0;
            end
            S_DONE: begin
                init_done_nx = 1'b1;
                reset_n_nx   = 1'b1;
                cke_nx       = 1'b1;
                cs_n_nx      = 1'b0;
            end
            default: ;
        endcase

        if (issue_mrs) begin
            ras_n_nx = 1'b0;
            cas_n_nx = 1'b0;
            we_n_nx  = 1'b0;
            case (idx_nx)
                2'd0: begin bank_nx = C_BANK_WIDTH'(2); addr_nx = MR2_VAL; end
                2'd1: begin bank_nx = C_BANK_WIDTH'(3); addr_nx = MR3_VAL; end
                2'd2: begin bank_nx = C_BANK_WIDTH'(1); addr_nx = MR1_VAL; end
                default: begin bank_nx = C_BANK_WIDTH'(0); addr_nx = MR0_VAL; end
            endcase
        end

        if (issue_zq) begin
            we_n_nx = 1'b0;
            addr_nx = ZQ_ADDR;
        end
    end

endmodule

// File: tb/tb_dfi_init_seq.sv
// Randomised bench for dfi_init_seq: every cycle of a run is compared with a
// schedule derived from the interval arithmetic of the init sequence.
module tb_dfi_init_seq;

    localparam int TR   = 10;
    localparam int TC   = 20;
    localparam int TX   = 5;
    localparam int TMRD = 4;
    localparam int TMOD = 12;
    localparam int TZQ  = 16;

    localparam logic [28:0] RESET_VEC = {10'b00_0000_1111, 3'd0, 16'h0000};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        init_done;
    logic        busy;
    logic        dfi_init_start;
    logic        dfi_init_complete;
    logic [15:0] dfi_address;
    logic [2:0]  dfi_bank;
    logic        dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_cs_n;
    logic        dfi_cke, dfi_odt, dfi_reset_n;

    int nvec = 0;
    int nerr = 0;

    dfi_init_seq #(
        .C_ROW_WIDTH  (16),
        .C_BANK_WIDTH (3),
        .T_RESET_CYC  (TR),
        .T_CKE_CYC    (TC),
        .T_XPR_CYC    (TX),
        .T_MRD_CYC    (TMRD),
        .T_MOD_CYC    (TMOD),
        .T_ZQINIT_CYC (TZQ),
        .MR0_VAL      (16'h0520),
        .MR1_VAL      (16'h0044),
        .MR2_VAL      (16'h0008),
        .MR3_VAL      (16'h0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .init_done         (init_done),
        .busy              (busy),
        .dfi_init_start    (dfi_init_start),
        .dfi_init_complete (dfi_init_complete),
        .dfi_address       (dfi_address),
        .dfi_bank          (dfi_bank),
        .dfi_ras_n         (dfi_ras_n),
        .dfi_cas_n         (dfi_cas_n),
        .dfi_we_n          (dfi_we_n),
        .dfi_cs_n          (dfi_cs_n),
        .dfi_cke           (dfi_cke),
        .dfi_odt           (dfi_odt),
        .dfi_reset_n       (dfi_reset_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] observe();
        return {init_done, busy, dfi_init_start, dfi_reset_n, dfi_cke, dfi_odt,
                dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address};
    endfunction

    // Expected bus r cycles after the edge that took start, with the PHY
    // handshake lasting d cycles.
    function automatic logic [28:0] expect_at(input int r, input int d);
        logic done_e, busy_e, ist, rstn, cke, cs, ras, cas, we;
        logic [2:0]  ba;
        logic [15:0] ad;
        int a, m0, z, f, k;
        a  = d + TR + TC;
        m0 = a + TX;
        z  = m0 + 3 * TMRD + TMOD;
        f  = z + TZQ;
        done_e = 0; busy_e = 1; ist = 0; rstn = 0; cke = 0;
        cs = 1; ras = 1; cas = 1; we = 1; ba = 3'd0; ad = 16'h0000;
        if (r < d) begin
            ist = 1;
        end else if (r < d + TR) begin
            rstn = 0;
        end else if (r < a) begin
            rstn = 1;
        end else begin
            rstn = 1; cke = 1; cs = 0;
            if (r >= f) begin
                done_e = 1; busy_e = 0;
            end else if (r == z) begin
                we = 0; ad = 16'h0400;
            end else if (r >= m0 && r <= m0 + 3 * TMRD && ((r - m0) % TMRD) == 0) begin
                k = (r - m0) / TMRD;
                ras = 0; cas = 0; we = 0;
                case (k)
                    0: begin ba = 3'd2; ad = 16'h0008; end
                    1: begin ba = 3'd3; ad = 16'h0000; end
                    2: begin ba = 3'd1; ad = 16'h0044; end
                    default: begin ba = 3'd0; ad = 16'h0520; end
                endcase
            end
        end
        return {done_e, busy_e, ist, rstn, cke, 1'b0, cs, ras, cas, we, ba, ad};
    endfunction

    function automatic int done_cycle(input int d);
        return d + TR + TC + TX + 3 * TMRD + TMOD + TZQ;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        dfi_init_complete = 1'b0;
        @(negedge clk);
        check("in_reset", 32'(observe()), 32'(RESET_VEC));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle", 32'(observe()), 32'(RESET_VEC));
    endtask

    // One sequence run; abort_at >= 0 pulls rst_n inside that cycle.
    task automatic run_seq(input int d_in, input bit pre, input bit noise,
                           input int abort_at, input int post);
        int d, f, done_at;
        logic [28:0] v;
        d = pre ? 1 : d_in;
        f = done_cycle(d);
        done_at = -1;
        dfi_init_complete = pre;
        start = 1'b1;
        for (int r = 0; r < f + post; r++) begin
            @(negedge clk);
            v = observe();
            check($sformatf("bus_r%0d_d%0d", r, d), 32'(v), 32'(expect_at(r, d)));
            if (v[28] && done_at < 0) done_at = r;
            start = noise ? 1'($urandom) : 1'b0;
            if (!pre && r == d - 1) dfi_init_complete = 1'b1;
            if (noise && r >= d) dfi_init_complete = 1'($urandom);
            if (r == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check("async_rst", 32'(observe()), 32'(RESET_VEC));
                start = 1'b0;
                dfi_init_complete = 1'b0;
                return;
            end
        end
        start = 1'b0;
        check("done_at", 32'(done_at), 32'(f));
    endtask

    initial begin
        int d, m0, ab;
        rst_n = 1'b0;
        start = 1'b0;
        dfi_init_complete = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("por", 32'(observe()), 32'(RESET_VEC));
        end
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            check("idle50", 32'(observe()), 32'(RESET_VEC));
        end

        // PHY answers after 7 cycles; full sequence timing.
        run_seq(7, 1'b0, 1'b0, -1, 5);

        // PHY already complete before start.
        do_reset();
        run_seq(1, 1'b1, 1'b0, -1, 5);

        // Reset in the gap between MR3 and MR1, then a clean rerun.
        do_reset();
        d  = int'($urandom_range(1, 9));
        m0 = d + TR + TC + TX;
        ab = m0 + TMRD + int'($urandom_range(1, TMRD - 1));
        run_seq(d, 1'b0, 1'b0, ab, 0);
        repeat (2) begin
            @(negedge clk);
            check("held_rst", 32'(observe()), 32'(RESET_VEC));
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_after", 32'(observe()), 32'(RESET_VEC));
        end
        run_seq(int'($urandom_range(1, 9)), 1'b0, 1'b0, -1, 3);

        // start toggling while busy, PHY complete wobbling after handshake.
        do_reset();
        run_seq(int'($urandom_range(1, 9)), 1'b0, 1'b1, -1, 30);

        repeat (4) begin
            do_reset();
            run_seq(int'($urandom_range(1, 9)), 1'($urandom), 1'($urandom), -1, 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
